// File: rtl/game_pkg.sv
// Shared definitions for the game processor's interrupt logic.
package game_pkg;

    localparam logic [1:0] IRQ_TIMER = 2'd0;
    localparam logic [1:0] IRQ_KBD   = 2'd1;
    localparam logic [1:0] IRQ_NONE  = 2'd3;

    localparam logic [1:0] IC_IDLE    = 2'd0;
    localparam logic [1:0] IC_PRESENT = 2'd1;
    localparam logic [1:0] IC_SERVICE = 2'd2;

endpackage

// File: rtl/irq_timer_divider.sv
// System tick generator: counts CLK cycles and pulses TICK once per TIMER_DIV cycles.
module irq_timer_divider
    import game_pkg::*;
#(
    parameter int TIMER_DIV = 833333,
    parameter int TIMER_W   = 24
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ENABLE,
    output logic TICK
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMER_DIV - 1);

    logic [TIMER_W-1:0] count;

    // Tick coincides with the wrap cycle, so a period is exactly TIMER_DIV cycles.
    assign TICK = ENABLE && (count == LAST_COUNT);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (!ENABLE || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches timer/keyboard events and presents one at a time to the processor.
module interrupt_controller
    import game_pkg::*;
#(
    parameter int TIMER_DIV = 833333,
    parameter int TIMER_W   = 24
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       KBD_STROBE,
    output logic [1:0] INT_IRQ,
    input  logic       INT_IACK,
    input  logic       INT_IEND,
    output logic [1:0] PENDING,
    output logic [1:0] OVERRUN,
    output logic       PROTO_ERR
);

    // Handshake: INT_IRQ != IRQ_NONE is a request; INT_IACK accepts it and drops INT_IRQ,
    // INT_IEND closes the service. Only one request is outstanding until INT_IEND.
    logic       tick;
    logic [1:0] events;
    logic [1:0] clearPend;
    logic [1:0] state;
    logic [1:0] stateNext;
    logic       srcKbd;
    logic       srcKbdNext;
    logic [1:0] irqNext;
    logic       protoViolation;

    irq_timer_divider #(
        .TIMER_DIV(TIMER_DIV),
        .TIMER_W  (TIMER_W)
    ) timerDivider (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .ENABLE (ENABLE),
        .TICK   (tick)
    );

    assign events = {KBD_STROBE & ENABLE, tick};

    // Set wins over clear so an event coinciding with its own IACK is not lost.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PENDING   <= '0;
            OVERRUN   <= '0;
            PROTO_ERR <= 1'b0;
        end else if (!ENABLE) begin
            PENDING   <= '0;
            OVERRUN   <= '0;
            PROTO_ERR <= 1'b0;
        end else begin
            PENDING   <= (PENDING & ~clearPend) | events;
            OVERRUN   <= OVERRUN | (events & PENDING & ~clearPend);
            PROTO_ERR <= PROTO_ERR | protoViolation;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IC_IDLE;
            srcKbd  <= 1'b0;
            INT_IRQ <= IRQ_NONE;
        end else if (!ENABLE) begin
            state   <= IC_IDLE;
            srcKbd  <= 1'b0;
            INT_IRQ <= IRQ_NONE;
        end else begin
            state   <= stateNext;
            srcKbd  <= srcKbdNext;
            INT_IRQ <= irqNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IC_IDLE:    if (|PENDING) stateNext = IC_PRESENT;
            IC_PRESENT: if (INT_IACK) stateNext = IC_SERVICE;
            IC_SERVICE: if (INT_IEND) stateNext = IC_IDLE;
            default:    stateNext = IC_IDLE;
        endcase
    end

    // The source is chosen once on leaving IDLE and then frozen until the service ends.
    always_comb begin
        irqNext        = INT_IRQ;
        srcKbdNext     = srcKbd;
        clearPend      = 2'b00;
        protoViolation = 1'b0;
        case (state)
            IC_IDLE: begin
                protoViolation = INT_IACK | INT_IEND;
                irqNext        = IRQ_NONE;
                if (|PENDING) begin
                    srcKbdNext = PENDING[1];
                    irqNext    = PENDING[1] ? IRQ_KBD : IRQ_TIMER;
                end
            end
            IC_PRESENT: begin
                protoViolation = INT_IEND;
                if (INT_IACK) begin
                    clearPend = srcKbd ? 2'b10 : 2'b01;
                    irqNext   = IRQ_NONE;
                end
            end
            IC_SERVICE: begin
                protoViolation = INT_IACK;
                irqNext        = IRQ_NONE;
            end
            default: irqNext = IRQ_NONE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller with a short timer period and a cycle-level reference model.
module tb_interrupt_controller;

    localparam int DIV = 10;
    localparam logic [1:0] C_TIMER = 2'd0;
    localparam logic [1:0] C_KBD   = 2'd1;
    localparam logic [1:0] C_NONE  = 2'd3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       ENABLE;
    logic       KBD_STROBE;
    logic       INT_IACK;
    logic       INT_IEND;
    logic [1:0] INT_IRQ;
    logic [1:0] PENDING;
    logic [1:0] OVERRUN;
    logic       PROTO_ERR;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: phase 0 = waiting, 1 = request shown, 2 = being serviced.
    int         mPhase;
    int         mSrc;
    int         mCnt;
    logic [1:0] mIrq;
    logic [1:0] mPend;
    logic [1:0] mOv;
    logic       mErr;
    logic [6:0] exp_q[$];

    interrupt_controller #(
        .TIMER_DIV(DIV),
        .TIMER_W  (24)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ENABLE    (ENABLE),
        .KBD_STROBE(KBD_STROBE),
        .INT_IRQ   (INT_IRQ),
        .INT_IACK  (INT_IACK),
        .INT_IEND  (INT_IEND),
        .PENDING   (PENDING),
        .OVERRUN   (OVERRUN),
        .PROTO_ERR (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic modelReset();
        mPhase = 0;
        mSrc   = 0;
        mCnt   = 0;
        mIrq   = C_NONE;
        mPend  = 2'b00;
        mOv    = 2'b00;
        mErr   = 1'b0;
    endtask

    task automatic modelStep();
        logic       tick;
        logic [1:0] ev;
        logic [1:0] clr;
        if (!RESET_N || !ENABLE) begin
            modelReset();
        end else begin
            tick = ((mCnt % DIV) == DIV - 1);
            ev   = {KBD_STROBE, tick};
            clr  = 2'b00;
            case (mPhase)
                0: begin
                    if (INT_IACK || INT_IEND) mErr = 1'b1;
                    if (mPend != 2'b00) begin
                        mSrc   = mPend[1] ? 1 : 0;
                        mIrq   = (mSrc == 1) ? C_KBD : C_TIMER;
                        mPhase = 1;
                    end
                end
                1: begin
                    if (INT_IEND) mErr = 1'b1;
                    if (INT_IACK) begin
                        clr[mSrc] = 1'b1;
                        mIrq      = C_NONE;
                        mPhase    = 2;
                    end
                end
                default: begin
                    if (INT_IACK) mErr = 1'b1;
                    if (INT_IEND) mPhase = 0;
                end
            endcase
            mOv   = mOv | (ev & mPend & ~clr);
            mPend = (mPend & ~clr) | ev;
            mCnt++;
        end
        exp_q.push_back({mIrq, mPend, mOv, mErr});
    endtask

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, then one-cycle pulses drop.
    task automatic cycle();
        @(posedge CLK);
        modelStep();
        cyc++;
        #1;
        KBD_STROBE = 1'b0;
        INT_IACK   = 1'b0;
        INT_IEND   = 1'b0;
    endtask

    task automatic runTo(int n);
        while (cyc < n) cycle();
    endtask

    task automatic asyncReset();
        #1 RESET_N = 1'b0;
        modelReset();
        exp_q.delete();
        exp_q.push_back({mIrq, mPend, mOv, mErr});
        #1;
        check("rst_irq", INT_IRQ, C_NONE);
        check("rst_pend", PENDING, 2'b00);
        check("rst_ovr", OVERRUN, 2'b00);
        check("rst_err", PROTO_ERR, 1'b0);
        RESET_N = 1'b1;
        cyc = 0;
    endtask

    // Scoreboard: every falling edge compares the outputs with the model snapshot.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({INT_IRQ, PENDING, OVERRUN, PROTO_ERR} !== e) begin
                    errors++;
                    $display("FAIL cycle_cmp: got irq=%0d pend=%b ovr=%b err=%b expected irq=%0d pend=%b ovr=%b err=%b (cycle %0d)",
                             INT_IRQ, PENDING, OVERRUN, PROTO_ERR, e[6:5], e[4:3], e[2:1], e[0], cyc);
                end
            end
        end
    end

    initial begin
        RESET_N    = 1'b0;
        ENABLE     = 1'b1;
        KBD_STROBE = 1'b0;
        INT_IACK   = 1'b0;
        INT_IEND   = 1'b0;
        modelReset();
        repeat (3) cycle();
        check("reset_irq", INT_IRQ, C_NONE);
        check("reset_pend", PENDING, 2'b00);
        RESET_N = 1'b1;
        cyc = 0;

        // First timer tick and a full service.
        runTo(9);   check("t1_pend9", PENDING, 2'b00);
        runTo(10);  check("t1_pend10", PENDING, 2'b01);
                    check("t1_irq10", INT_IRQ, C_NONE);
        runTo(11);  check("t1_irq11", INT_IRQ, C_TIMER);
        runTo(12);  INT_IACK = 1'b1;
        runTo(13);  check("t1_ack_irq", INT_IRQ, C_NONE);
                    check("t1_ack_pend", PENDING, 2'b00);
        runTo(14);  INT_IEND = 1'b1;
        runTo(20);  check("t1_wait_irq", INT_IRQ, C_NONE);
                    check("t1_tick2_pend", PENDING, 2'b01);
        runTo(21);  check("t1_tick2_irq", INT_IRQ, C_TIMER);

        // Keyboard and tick in the same cycle: keyboard first.
        INT_IACK = 1'b1; runTo(22);
        INT_IEND = 1'b1; runTo(23);
        runTo(29);  KBD_STROBE = 1'b1;
        runTo(30);  check("t2_pend", PENDING, 2'b11);
        runTo(31);  check("t2_irq_kbd", INT_IRQ, C_KBD);
        INT_IACK = 1'b1; runTo(32);
                    check("t2_pend_after_ack", PENDING, 2'b01);
        INT_IEND = 1'b1; runTo(33);
                    check("t2_gap_irq", INT_IRQ, C_NONE);
        runTo(34);  check("t2_irq_timer", INT_IRQ, C_TIMER);

        // Two key strobes during timer service merge into one request.
        INT_IACK = 1'b1; runTo(35);
        KBD_STROBE = 1'b1; runTo(36);
        runTo(38);  KBD_STROBE = 1'b1;
        runTo(39);  check("t3_pend", PENDING, 2'b10);
                    check("t3_ovr", OVERRUN, 2'b10);
        runTo(40);  INT_IEND = 1'b1;
        runTo(41);
        runTo(42);  check("t3_irq_kbd", INT_IRQ, C_KBD);
        INT_IACK = 1'b1; runTo(43);
                    check("t3_pend_ack", PENDING, 2'b01);
        INT_IEND = 1'b1; runTo(44);
        runTo(45);  check("t3_irq_timer", INT_IRQ, C_TIMER);

        // Key strobe coinciding with the IACK of a keyboard request.
        INT_IACK = 1'b1; runTo(46);
        INT_IEND = 1'b1; runTo(47);
        KBD_STROBE = 1'b1; runTo(48);
        runTo(49);  check("t4_irq_kbd", INT_IRQ, C_KBD);
        INT_IACK = 1'b1; KBD_STROBE = 1'b1; runTo(50);
                    check("t4_pend", PENDING, 2'b11);
                    check("t4_ovr", OVERRUN, 2'b10);
        INT_IEND = 1'b1; runTo(51);
        runTo(52);  check("t4_irq_kbd2", INT_IRQ, C_KBD);
        INT_IACK = 1'b1; runTo(53);
        INT_IEND = 1'b1; runTo(54);
        runTo(55);  check("t4_irq_timer", INT_IRQ, C_TIMER);

        // Protocol errors.
        INT_IEND = 1'b1; runTo(56);
                    check("t5_err", PROTO_ERR, 1'b1);
                    check("t5_irq_held", INT_IRQ, C_TIMER);
        INT_IACK = 1'b1; runTo(57);
        INT_IEND = 1'b1; runTo(58);
        INT_IACK = 1'b1; runTo(59);
                    check("t5_idle_iack_irq", INT_IRQ, C_NONE);
                    check("t5_idle_iack_pend", PENDING, 2'b00);
        runTo(61);  check("t5_next_irq", INT_IRQ, C_TIMER);

        // Asynchronous reset in the middle of a service.
        INT_IACK = 1'b1; runTo(62);
        KBD_STROBE = 1'b1; runTo(63);
        asyncReset();
        runTo(4);   INT_IEND = 1'b1;
        runTo(5);   check("t6_idle_iend_err", PROTO_ERR, 1'b1);
        runTo(9);   check("t6_pend9", PENDING, 2'b00);
        runTo(10);  check("t6_pend10", PENDING, 2'b01);

        // One cycle of ENABLE low clears everything and restarts the tick period.
        ENABLE = 1'b0; KBD_STROBE = 1'b1;
        runTo(11);  check("t6_dis_irq", INT_IRQ, C_NONE);
                    check("t6_dis_pend", PENDING, 2'b00);
                    check("t6_dis_err", PROTO_ERR, 1'b0);
        ENABLE = 1'b1;
        runTo(20);  check("t6_re_pend20", PENDING, 2'b00);
        runTo(21);  check("t6_re_pend21", PENDING, 2'b01);
        runTo(22);  check("t6_re_irq", INT_IRQ, C_TIMER);
        runTo(24);
        @(negedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
